// File: rtl/cycle_meas_sched.sv
// cycle_meas_sched: round-robin sharing of one cycle counter between NREQ interval-measuring requesters
module cycle_meas_sched #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 28,
    parameter int TIMEOUT = 2**24,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [NREQ-1:0]  req_start_i,
    input  logic [NREQ-1:0]  req_end_i,
    output logic [NREQ-1:0]  grant_o,
    output logic             busy_o,
    output logic             cnt_start_o,
    output logic             cnt_end_o,
    input  logic [WIDTH-1:0] cnt_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [IDW-1:0]   res_id_o,
    output logic [WIDTH-1:0] res_cnt_o,
    output logic             res_ovf_o
);
    localparam logic [WIDTH-1:0] TO  = WIDTH'(TIMEOUT);
    localparam logic [NREQ-1:0]  ONE = NREQ'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_END, S_RESP} state_t;

    state_t            state_q;
    logic [NREQ-1:0]   pend_q, pend_d;
    logic [IDW-1:0]    last_q, win_id, idx;
    logic [NREQ-1:0]   win_oh, grant_q;
    logic              grant_now;
    logic              busy_q, cnt_start_q, cnt_end_q, ovf_q;
    logic              res_valid_q, res_ovf_q;
    logic [IDW-1:0]    res_id_q;
    logic [WIDTH-1:0]  res_cnt_q;

    // Round-robin pick starting after last winner; pending set beats grant clear
    always_comb begin
        win_id = last_q;
        idx    = last_q;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IDW'((int'(last_q) + k) % NREQ);
            if (pend_q[idx]) win_id = idx;
        end
        grant_now = (state_q == S_IDLE) && (|pend_q);
        win_oh    = grant_now ? (ONE << win_id) : '0;
        pend_d    = (pend_q & ~win_oh) | req_start_i;
    end

    // Scheduler FSM; the timeout check skips the first RUN edge because cnt still holds the previous run's frozen value
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            pend_q      <= '0;
            last_q      <= IDW'(NREQ - 1);
            grant_q     <= '0;
            busy_q      <= 1'b0;
            cnt_start_q <= 1'b0;
            cnt_end_q   <= 1'b0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_cnt_q   <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            pend_q <= pend_d;
            case (state_q)
                S_IDLE: begin
                    if (grant_now) begin
                        grant_q     <= win_oh;
                        last_q      <= win_id;
                        cnt_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_RUN;
                    end
                end
                S_RUN: begin
                    cnt_start_q <= 1'b0;
                    if (!cnt_start_q && cnt_i >= TO) begin
                        cnt_end_q <= 1'b1;
                        ovf_q     <= 1'b1;
                        state_q   <= S_END;
                    end else if (req_end_i[last_q]) begin
                        cnt_end_q <= 1'b1;
                        state_q   <= S_END;
                    end
                end
                S_END: begin
                    cnt_end_q   <= 1'b0;
                    grant_q     <= '0;
                    res_cnt_q   <= ovf_q ? TO : cnt_i;
                    res_ovf_q   <= ovf_q;
                    res_id_q    <= last_q;
                    res_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        ovf_q       <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign grant_o     = grant_q;
    assign busy_o      = busy_q;
    assign cnt_start_o = cnt_start_q;
    assign cnt_end_o   = cnt_end_q;
    assign res_valid_o = res_valid_q;
    assign res_id_o    = res_id_q;
    assign res_cnt_o   = res_cnt_q;
    assign res_ovf_o   = res_ovf_q;
endmodule

// File: tb/tb_cycle_meas_sched.sv
// tb_cycle_meas_sched: directed checks of arbitration, counting, timeout, backpressure and reset
module tb_cycle_meas_sched;
    localparam int NREQ = 4, WIDTH = 8, TIMEOUT = 16, IDW = 2;

    logic             clk = 1'b0, reset = 1'b1;
    logic [NREQ-1:0]  req_start = '0, req_end = '0, grant;
    logic             busy, cnt_start, cnt_end, res_valid, res_ready = 1'b0, res_ovf;
    logic [WIDTH-1:0] cnt, res_cnt;
    logic [IDW-1:0]   res_id;
    logic             run;
    int               checks = 0, errors = 0, n;

    cycle_meas_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .reset_i(reset), .req_start_i(req_start), .req_end_i(req_end),
        .grant_o(grant), .busy_o(busy), .cnt_start_o(cnt_start), .cnt_end_o(cnt_end),
        .cnt_i(cnt), .res_valid_o(res_valid), .res_ready_i(res_ready), .res_id_o(res_id),
        .res_cnt_o(res_cnt), .res_ovf_o(res_ovf)
    );

    always #5 clk = ~clk;

    // Shared counter: start loads 1, runs until end freezes it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (cnt_start) begin
            cnt <= 8'd1;
            run <= 1'b1;
        end else if (cnt_end) begin
            run <= 1'b0;
        end else if (run) begin
            cnt <= cnt + 8'd1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic await_grant(input logic [NREQ-1:0] exp, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (grant == '0 && cycles < 20);
        check("grant", grant, exp);
        check("cnt_start_rise", cnt_start, 1);
        check("busy_rise", busy, 1);
    endtask

    task automatic serve(input int id, input int len, input logic [NREQ-1:0] extra, input logic [NREQ-1:0] foreign);
        logic [NREQ-1:0] oh;
        oh = 4'b0001 << id;
        for (int i = 1; i < len; i++) begin
            req_start = (i == 1) ? extra : '0;
            req_end   = foreign;
            tick();
            if (i == 1) check("cnt_start_fall", cnt_start, 0);
        end
        req_start = '0;
        check("no_early_end", cnt_end, 0);
        req_end = oh;
        tick();
        req_end = '0;
        check("cnt_end", cnt_end, 1);
        check("grant_hold", grant, oh);
        tick();
        check("res_valid", res_valid, 1);
        check("res_id", res_id, id);
        check("res_cnt", res_cnt, len);
        check("res_ovf", res_ovf, 0);
        check("grant_drop", grant, 0);
        check("cnt_end_fall", cnt_end, 0);
    endtask

    task automatic accept();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("res_valid_fall", res_valid, 0);
        check("busy_fall", busy, 0);
    endtask

    task automatic pulse_start(input logic [NREQ-1:0] v);
        req_start = v;
        tick();
        req_start = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        check("reset_outs", {grant, busy, cnt_start, cnt_end, res_valid, res_id, res_cnt, res_ovf}, 0);
        reset = 1'b0;
        tick();
        // single measurement on requester 2
        pulse_start(4'b0100);
        await_grant(4'b0100, n);
        check("grant_latency", n, 1);
        serve(2, 10, '0, '0);
        accept();
        // minimum interval
        pulse_start(4'b0001);
        await_grant(4'b0001, n);
        serve(0, 1, '0, '0);
        accept();
        // end pulse on the grant edge is ignored
        req_start = 4'b0001;
        tick();
        req_start = '0;
        req_end   = 4'b0001;
        await_grant(4'b0001, n);
        req_end = '0;
        serve(0, 4, '0, '0);
        accept();
        // round robin after a fresh reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        res_ready = 1'b1;
        pulse_start(4'b1011);
        await_grant(4'b0001, n);
        serve(0, 5, '0, '0);
        await_grant(4'b0010, n);
        check("handoff", n, 2);
        serve(1, 5, '0, '0);
        await_grant(4'b1000, n);
        serve(3, 5, 4'b0001, '0);
        await_grant(4'b0001, n);
        serve(0, 5, '0, '0);
        tick();
        res_ready = 1'b0;
        // timeout, with a coincident end and then with no end at all
        for (int v = 0; v < 2; v++) begin
            pulse_start(4'b0010);
            await_grant(4'b0010, n);
            for (int i = 0; i < 16; i++) tick();
            check("to_not_yet", cnt_end, 0);
            req_end = (v == 0) ? 4'b0010 : 4'b0000;
            tick();
            req_end = '0;
            check("to_cnt_end", cnt_end, 1);
            tick();
            check("to_valid", res_valid, 1);
            check("to_id", res_id, 1);
            check("to_cnt", res_cnt, TIMEOUT);
            check("to_ovf", res_ovf, 1);
            accept();
        end
        // backpressure with foreign end pulses and a queued requester
        pulse_start(4'b0010);
        await_grant(4'b0010, n);
        serve(1, 6, 4'b0100, 4'b1000);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_valid", res_valid, 1);
            check("bp_fields", {res_id, res_cnt, res_ovf}, {2'd1, 8'd6, 1'b0});
            check("bp_no_grant", grant, 0);
            check("bp_busy", busy, 1);
        end
        accept();
        await_grant(4'b0100, n);
        check("bp_handoff", n, 1);
        // reset in the middle of a run with requests pending
        pulse_start(4'b1010);
        tick();
        reset = 1'b1;
        #1;
        check("rst_outs", {grant, busy, cnt_start, cnt_end, res_valid, res_id, res_cnt, res_ovf}, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("rst_no_grant", grant, 0);
        check("rst_idle", busy, 0);
        pulse_start(4'b0001);
        await_grant(4'b0001, n);
        check("rst_regrant", n, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
